cv32e40px_illegal_insn_fifo: RTL and testbench

Synthesizable capture buffer for illegal-instruction events detected in the decode stage of the cv32e40px core. It watches the same decode-stage qualifiers the core's simulation logger uses. It records each distinct illegal-instruction occurrence with its PC, instruction word and a cycle stamp in a small FIFO, and exposes the entries over a valid/ready port to a downstream debug/trace consumer. Drop, overflow and total-event statistics are maintained alongside the FIFO.

---
 rtl/cv32e40px_illegal_insn_fifo_if.sv | 27 ++
 rtl/cv32e40px_illegal_insn_fifo.sv | 137 +++++++++++++
 tb/tb_cv32e40px_illegal_insn_fifo.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40px_illegal_insn_fifo_if.sv
// Event read port of the illegal-instruction capture FIFO.
// The FIFO drives valid and the head entry. The consumer drives ready.
interface cv32e40px_illegal_insn_fifo_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 evt_valid_o;
  logic                 evt_ready_i;
  logic [31:0]          evt_pc_o;
  logic [31:0]          evt_instr_o;
  logic [CNT_WIDTH-1:0] evt_stamp_o;

  modport master (
    output evt_valid_o,
    output evt_pc_o,
    output evt_instr_o,
    output evt_stamp_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o,
    input  evt_pc_o,
    input  evt_instr_o,
    input  evt_stamp_o,
    output evt_ready_i
  );
endinterface

// File: rtl/cv32e40px_illegal_insn_fifo.sv
// Capture buffer for illegal-instruction events seen in decode.
// Each distinct event is stored as {PC, instruction, cycle stamp} in a
// first-word-fall-through circular FIFO, with saturating event and drop
// counters and a sticky overflow flag. A decode stall that holds the same
// illegal instruction produces only one event.
module cv32e40px_illegal_insn_fifo #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic                         is_decoding_i,
  input  logic                         illegal_insn_dec_i,
  input  logic [31:0]                  pc_id_i,
  input  logic [31:0]                  instr_id_i,
  cv32e40px_illegal_insn_fifo_if.master evt,
  output logic [$clog2(DEPTH):0]       level_o,
  output logic                         overflow_o,
  output logic [CNT_WIDTH-1:0]         illegal_cnt_o,
  output logic [CNT_WIDTH-1:0]         drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [31:0]          r_mem_pc    [DEPTH];
  logic [31:0]          r_mem_instr [DEPTH];
  logic [CNT_WIDTH-1:0] r_mem_stamp [DEPTH];

  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic [CNT_WIDTH-1:0] r_stamp;
  logic                 r_rep_flag;
  logic [31:0]          r_rep_pc;
  logic                 r_overflow;
  logic [CNT_WIDTH-1:0] r_illegal_cnt;
  logic [CNT_WIDTH-1:0] r_drop_cnt;

  logic w_raw;
  logic w_repeat;
  logic w_new;
  logic w_valid;
  logic w_pop;
  logic w_space;
  logic w_push;
  logic w_drop;

  // Event qualification and FIFO handshake decisions.
  always_comb begin
    w_raw    = is_decoding_i & illegal_insn_dec_i;
    w_repeat = w_raw & r_rep_flag & (pc_id_i == r_rep_pc);
    w_new    = w_raw & ~w_repeat;
    w_valid  = (r_level != '0);
    w_pop    = w_valid & evt.evt_ready_i;
    // A pop in the same cycle frees the slot the push needs, even when full.
    w_space  = (r_level < FULL_LVL) | w_pop;
    w_push   = w_new & w_space & ~clear_i;
    w_drop   = w_new & ~w_space & ~clear_i;
  end

  // Free-running stamp counter; only reset clears it, not clear_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stamp <= '0;
    else        r_stamp <= r_stamp + CNT_WIDTH'(1);
  end

  // Repeat-suppression history: was there a raw event last cycle, and at which PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_flag <= 1'b0;
      r_rep_pc   <= '0;
    end else begin
      r_rep_flag <= w_raw & ~clear_i;
      r_rep_pc   <= pc_id_i;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Entry storage; contents are only observed while the entry is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= pc_id_i;
      r_mem_instr[r_wr_ptr] <= instr_id_i;
      r_mem_stamp[r_wr_ptr] <= r_stamp;
    end
  end

  // Saturating statistics and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
      r_drop_cnt    <= '0;
      r_overflow    <= 1'b0;
    end else if (clear_i) begin
      r_illegal_cnt <= '0;
      r_drop_cnt    <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_new && (r_illegal_cnt != '1)) r_illegal_cnt <= r_illegal_cnt + CNT_WIDTH'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign evt.evt_valid_o = w_valid;
  assign evt.evt_pc_o    = w_valid ? r_mem_pc[r_rd_ptr]    : '0;
  assign evt.evt_instr_o = w_valid ? r_mem_instr[r_rd_ptr] : '0;
  assign evt.evt_stamp_o = w_valid ? r_mem_stamp[r_rd_ptr] : '0;
  assign level_o         = r_level;
  assign overflow_o      = r_overflow;
  assign illegal_cnt_o   = r_illegal_cnt;
  assign drop_cnt_o      = r_drop_cnt;
endmodule

// File: tb/tb_cv32e40px_illegal_insn_fifo.sv
// Bench for the illegal-instruction capture FIFO: directed scenarios plus
// randomized traffic checked against a queue-based reference model.
module tb_cv32e40px_illegal_insn_fifo;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int LW    = 3;
  localparam int VW    = 1 + 32 + 32 + CW + LW + 1 + CW + CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_i = 1'b0;
  logic          dec = 1'b0;
  logic          ill = 1'b0;
  logic [31:0]   pc = '0;
  logic [31:0]   instr = '0;
  logic [LW-1:0] level;
  logic          ovf;
  logic [CW-1:0] ill_cnt;
  logic [CW-1:0] drop_cnt;

  cv32e40px_illegal_insn_fifo_if #(.CNT_WIDTH(CW)) evt_if ();

  cv32e40px_illegal_insn_fifo #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .clear_i            (clear_i),
    .is_decoding_i      (dec),
    .illegal_insn_dec_i (ill),
    .pc_id_i            (pc),
    .instr_id_i         (instr),
    .evt                (evt_if),
    .level_o            (level),
    .overflow_o         (ovf),
    .illegal_cnt_o      (ill_cnt),
    .drop_cnt_o         (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic [CW-1:0] stamp;
  } ent_t;

  // Reference model state.
  ent_t          m_q[$];
  logic [CW-1:0] m_stamp, m_ill, m_drop;
  logic          m_ovf, m_prev_raw;
  logic [31:0]   m_prev_pc;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {evt_if.evt_valid_o, evt_if.evt_pc_o, evt_if.evt_instr_o,
                    evt_if.evt_stamp_o, level, ovf, ill_cnt, drop_cnt};

  function automatic logic [VW-1:0] model_vec();
    ent_t h;
    h = (m_q.size() > 0) ? m_q[0] : '0;
    return {m_q.size() > 0, h.pc, h.instr, h.stamp, LW'(m_q.size()), m_ovf, m_ill, m_drop};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_stamp = '0; m_ill = '0; m_drop = '0;
    m_ovf = 1'b0; m_prev_raw = 1'b0; m_prev_pc = '0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit.
  task automatic step(input logic d, input logic il, input logic [31:0] p,
                      input logic [31:0] w, input logic rdy, input logic clr);
    logic raw, nw, pop;
    dec = d; ill = il; pc = p; instr = w; evt_if.evt_ready_i = rdy; clear_i = clr;
    @(posedge clk);
    raw = d & il;
    nw  = raw && !(m_prev_raw && (p == m_prev_pc));
    pop = (m_q.size() > 0) && rdy;
    if (clr) begin
      m_q.delete(); m_ill = '0; m_drop = '0; m_ovf = 1'b0; m_prev_raw = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (nw) begin
        if (m_ill != '1) m_ill = m_ill + 1'b1;
        if (m_q.size() < DEPTH) m_q.push_back(ent_t'{p, w, m_stamp});
        else begin
          if (m_drop != '1) m_drop = m_drop + 1'b1;
          m_ovf = 1'b1;
        end
      end
      m_prev_raw = raw;
    end
    m_prev_pc = p;
    m_stamp = m_stamp + 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    evt_if.evt_ready_i = 1'b0;
    #3;
    n_cmp++;
    if (dut_vec !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    idle(5);
    step(1'b1, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0);
    n_cmp++;
    if ({evt_if.evt_valid_o, evt_if.evt_pc_o, evt_if.evt_stamp_o, level, ill_cnt}
        !== {1'b1, 32'h100, 16'd5, 3'd1, 16'd1}) begin
      n_bad++;
      $display("FAIL single_capture: got v=%b pc=%h st=%0d lvl=%0d ill=%0d want v=1 pc=100 st=5 lvl=1 ill=1",
               evt_if.evt_valid_o, evt_if.evt_pc_o, evt_if.evt_stamp_o, level, ill_cnt);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (evt_if.evt_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL single_pop: got valid=%b want 0", evt_if.evt_valid_o);
    end
  endtask

  task automatic test_repeat();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h200, 32'hdead_0200, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 32'h200, 32'hdead_0200, 1'b0, 1'b0);
    n_cmp++;
    if ({level, ill_cnt} !== {3'd2, 16'd2}) begin
      n_bad++; $display("FAIL repeat_suppress: got lvl=%0d ill=%0d want lvl=2 ill=2", level, ill_cnt);
    end
    n_cmp++;
    if (dut_vec !== model_vec()) begin
      n_bad++; $display("FAIL repeat_model: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] k;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    k = m_stamp;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h300 + 32'(4*i), 32'h1000 + 32'(i), 1'b0, 1'b0);
    n_cmp++;
    if (level !== 3'd3) begin
      n_bad++; $display("FAIL b2b_level: got %0d want 3", level);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({evt_if.evt_valid_o, evt_if.evt_pc_o, evt_if.evt_instr_o, evt_if.evt_stamp_o}
          !== {1'b1, 32'h300 + 32'(4*i), 32'h1000 + 32'(i), k + CW'(i)}) begin
        n_bad++;
        $display("FAIL b2b_entry%0d: got pc=%h instr=%h st=%0d want pc=%h instr=%h st=%0d", i,
                 evt_if.evt_pc_o, evt_if.evt_instr_o, evt_if.evt_stamp_o,
                 32'h300 + 32'(4*i), 32'h1000 + 32'(i), k + CW'(i));
      end
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    n_cmp++;
    if (evt_if.evt_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL b2b_empty: got valid=%b want 0", evt_if.evt_valid_o);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h404, 32'h408, 32'h40c, 32'h500};
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 32'h400 + 32'(4*i), 32'(i), 1'b0, 1'b0);
    n_cmp++;
    if ({level, drop_cnt, ovf, ill_cnt} !== {3'd4, 16'd2, 1'b1, 16'd6}) begin
      n_bad++; $display("FAIL overflow_stats: got lvl=%0d drop=%0d ovf=%b ill=%0d want 4 2 1 6",
                        level, drop_cnt, ovf, ill_cnt);
    end
    step(1'b1, 1'b1, 32'h500, 32'h55, 1'b1, 1'b0);
    n_cmp++;
    if ({level, drop_cnt, ill_cnt} !== {3'd4, 16'd2, 16'd7}) begin
      n_bad++; $display("FAIL full_push_pop: got lvl=%0d drop=%0d ill=%0d want 4 2 7", level, drop_cnt, ill_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (evt_if.evt_pc_o !== exp_pc[i]) begin
        n_bad++; $display("FAIL overflow_order%0d: got %h want %h", i, evt_if.evt_pc_o, exp_pc[i]);
      end
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 32'h600 + 32'(4*i), $urandom, (i % 3) != 0, 1'b0);
      n_cmp++;
      if (dut_vec !== model_vec() || level > 3'd4) begin
        n_bad++; $display("FAIL wrap_cycle%0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL wrap_drain%0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_clear();
    logic [CW-1:0] s;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h700 + 32'(4*i), 32'(i), 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if ({level, ovf, drop_cnt} !== {3'd3, 1'b1, 16'd1}) begin
      n_bad++; $display("FAIL clear_setup: got lvl=%0d ovf=%b drop=%0d want 3 1 1", level, ovf, drop_cnt);
    end
    s = m_stamp;
    step(1'b1, 1'b1, 32'h7f0, 32'h77, 1'b1, 1'b1);
    n_cmp++;
    if (dut_vec !== '0) begin
      n_bad++; $display("FAIL clear_all: got %h want 0", dut_vec);
    end
    step(1'b1, 1'b1, 32'h7f0, 32'h78, 1'b0, 1'b0);
    n_cmp++;
    if ({evt_if.evt_valid_o, evt_if.evt_stamp_o, ill_cnt} !== {1'b1, s + CW'(1), 16'd1}) begin
      n_bad++; $display("FAIL clear_stamp_continues: got v=%b st=%0d ill=%0d want 1 %0d 1",
                        evt_if.evt_valid_o, evt_if.evt_stamp_o, ill_cnt, s + CW'(1));
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 32'h900, 32'h9, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h904, 32'ha, 1'b0, 1'b0);
    dec = 1'b0; ill = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== '0) begin
      n_bad++; $display("FAIL async_reset: got %h want 0", dut_vec);
    end
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b1, 32'h908, 32'hb, 1'b0, 1'b0);
    n_cmp++;
    if ({evt_if.evt_pc_o, evt_if.evt_stamp_o} !== {32'h908, 16'd0}) begin
      n_bad++; $display("FAIL reset_stamp: got pc=%h st=%0d want pc=908 st=0", evt_if.evt_pc_o, evt_if.evt_stamp_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] p;
    logic        d, il;
    for (int i = 0; i < 400; i++) begin
      d  = ($urandom_range(0, 3) != 0);
      il = ($urandom_range(0, 2) != 0);
      p  = 32'h800 + 32'(4 * $urandom_range(0, 2));
      step(d, il, p, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_back_to_back();
    test_overflow();
    test_wrap();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
